// File: rtl/cnn_pkg.sv
// Shared constants and types for the CNN datapath blocks.
package cnn_pkg;

    localparam int unsigned DW            = 18;
    localparam int unsigned L0_POOL_SIDE  = 13;
    localparam int unsigned L0_POOL_DEPTH = L0_POOL_SIDE * L0_POOL_SIDE;
    localparam int unsigned L0_POOL_AW    = 8;

    typedef logic signed [DW-1:0] feat_t;

    // One 2x2 pooling window as delivered by a layer_0 output RAM.
    typedef logic [3:0][DW-1:0] win_t;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } pool_state_t;

endpackage

// File: rtl/pool_max4.sv
// Combinational signed maximum of one 4-value pooling window.
module pool_max4
    import cnn_pkg::*;
(
    input  win_t  i_win,
    output feat_t o_max
);

    feat_t w_e0;
    feat_t w_e1;
    feat_t w_e2;
    feat_t w_e3;
    feat_t w_m01;
    feat_t w_m23;

    assign w_e0 = feat_t'(i_win[0]);
    assign w_e1 = feat_t'(i_win[1]);
    assign w_e2 = feat_t'(i_win[2]);
    assign w_e3 = feat_t'(i_win[3]);

    // Two-level compare tree; equal values make tie order irrelevant.
    assign w_m01 = (w_e0 > w_e1) ? w_e0 : w_e1;
    assign w_m23 = (w_e2 > w_e3) ? w_e2 : w_e3;
    assign o_max = (w_m01 > w_m23) ? w_m01 : w_m23;

endmodule

// File: rtl/l0_maxpool.sv
// 2x2 max-pool stage after layer_0: reduces windows, buffers a 13x13 map
// per channel, and hands the frame to layer_1 with a rdy/ack handshake.
module l0_maxpool
    import cnn_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  tx_done,
    input  logic                  in_rd,
    input  logic [3:0][DW-1:0]    din_0,
    input  logic [3:0][DW-1:0]    din_1,
    input  logic                  rd_en,
    input  logic [L0_POOL_AW-1:0] rd_addr,
    input  logic                  frame_ack,
    output logic [DW-1:0]         dout_0,
    output logic [DW-1:0]         dout_1,
    output logic                  frame_rdy,
    output logic                  ovf
);

    localparam logic [L0_POOL_AW-1:0] LAST_ADDR = L0_POOL_AW'(L0_POOL_DEPTH - 1);
    localparam logic [L0_POOL_AW-1:0] DEPTH_A   = L0_POOL_AW'(L0_POOL_DEPTH);

    pool_state_t           r_state;
    logic                  r_v1;
    logic                  r_v2;
    feat_t                 r_pool_0;
    feat_t                 r_pool_1;
    logic [L0_POOL_AW-1:0] r_wr_addr;
    logic                  r_ovf;
    logic [DW-1:0]         r_dout_0;
    logic [DW-1:0]         r_dout_1;
    logic [DW-1:0]         r_buf_0 [L0_POOL_DEPTH];
    logic [DW-1:0]         r_buf_1 [L0_POOL_DEPTH];

    feat_t                 w_max_0;
    feat_t                 w_max_1;
    logic                  w_accept;
    logic                  w_wr_en;
    logic                  w_rd_in_range;

    pool_max4 u_max_0 (
        .i_win (din_0),
        .o_max (w_max_0)
    );

    pool_max4 u_max_1 (
        .i_win (din_1),
        .o_max (w_max_1)
    );

    // A frame may be overwritten only when not held, or when released this cycle.
    assign w_accept      = (r_state == FILL) || frame_ack;
    assign w_wr_en       = r_v2 && w_accept && !tx_done;
    assign w_rd_in_range = (rd_addr < DEPTH_A);

    // Pipeline valids, pooled registers, write counter and FILL/FULL state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= FILL;
            r_v1      <= 1'b0;
            r_v2      <= 1'b0;
            r_pool_0  <= '0;
            r_pool_1  <= '0;
            r_wr_addr <= '0;
            r_ovf     <= 1'b0;
        end else if (tx_done) begin
            r_state   <= FILL;
            r_v1      <= 1'b0;
            r_v2      <= 1'b0;
            r_wr_addr <= '0;
            r_ovf     <= 1'b0;
        end else begin
            r_v1 <= in_rd;
            r_v2 <= r_v1;
            if (r_v1) begin
                r_pool_0 <= w_max_0;
                r_pool_1 <= w_max_1;
            end
            if ((r_state == FULL) && frame_ack) begin
                r_state <= FILL;
            end
            if (r_v2) begin
                if (w_accept) begin
                    if (r_wr_addr == LAST_ADDR) begin
                        r_wr_addr <= '0;
                        r_state   <= FULL;
                    end else begin
                        r_wr_addr <= r_wr_addr + 1'b1;
                    end
                end else begin
                    r_ovf <= 1'b1;
                end
            end
        end
    end

    // Frame buffer write port; contents deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_buf_0[r_wr_addr] <= r_pool_0;
            r_buf_1[r_wr_addr] <= r_pool_1;
        end
    end

    // Registered read port; same-cycle write to the same address yields old data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dout_0 <= '0;
            r_dout_1 <= '0;
        end else if (rd_en) begin
            r_dout_0 <= w_rd_in_range ? r_buf_0[rd_addr] : '0;
            r_dout_1 <= w_rd_in_range ? r_buf_1[rd_addr] : '0;
        end
    end

    assign dout_0    = r_dout_0;
    assign dout_1    = r_dout_1;
    assign frame_rdy = (r_state == FULL);
    assign ovf       = r_ovf;

endmodule
